// File: rtl/strip_allocator.sv
// Best-fit strip allocator: scans 13 fixed-height strips one per cycle and
// places each request in the shortest strip that still has room for it.
module strip_allocator #(
    parameter int NUM_STRIPS = 13,
    parameter int FABRIC_W   = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_in,
    input  logic       req_valid_in,
    output logic       req_ready_out,
    input  logic [7:0] req_w_in,
    input  logic [4:0] req_h_in,
    output logic       res_valid_out,
    input  logic       res_ready_in,
    output logic [3:0] strip_ID_out,
    output logic [7:0] occupied_width_out,
    output logic       strike_flag_out,
    output logic [1:0] o_dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends combinationally on ready, and a result is held
    // stable until it is taken.

    function automatic logic [4:0] strip_height(input logic [3:0] id);
        case (id)
            4'd1:    strip_height = 5'd8;
            4'd2:    strip_height = 5'd8;
            4'd3:    strip_height = 5'd9;
            4'd4:    strip_height = 5'd7;
            4'd5:    strip_height = 5'd10;
            4'd6:    strip_height = 5'd6;
            4'd7:    strip_height = 5'd11;
            4'd8:    strip_height = 5'd5;
            4'd9:    strip_height = 5'd12;
            4'd10:   strip_height = 5'd4;
            4'd11:   strip_height = 5'd16;
            4'd12:   strip_height = 5'd16;
            4'd13:   strip_height = 5'd16;
            default: strip_height = 5'd0;
        endcase
    endfunction

    logic [1:0] r_state;
    logic [3:0] r_idx;
    logic [7:0] r_w;
    logic [4:0] r_h;
    logic       r_legal;
    logic       r_best_found;
    logic [3:0] r_best_id;
    logic [4:0] r_best_h;
    logic [7:0] r_best_occ;
    logic [7:0] r_occ [1:NUM_STRIPS];
    logic       r_res_valid;
    logic [3:0] r_strip_id;
    logic [7:0] r_occ_w;
    logic       r_strike;

    logic [7:0] w_cur_occ;
    logic [4:0] w_cur_h;
    logic [8:0] w_sum;
    logic       w_fit;
    logic       w_better;
    logic       w_req_legal;

    always_comb begin
        w_cur_occ = 8'd0;
        for (int k = 1; k <= NUM_STRIPS; k++) begin
            if (r_idx == 4'(k)) w_cur_occ = r_occ[k];
        end
    end

    // Strips are scanned in ascending ID, so a strict "<" keeps the lowest ID on a height tie.
    assign w_cur_h     = strip_height(r_idx);
    assign w_sum       = {1'b0, w_cur_occ} + {1'b0, r_w};
    assign w_fit       = r_legal && (w_cur_h >= r_h) && (w_sum <= 9'(FABRIC_W));
    assign w_better    = w_fit && (!r_best_found || (w_cur_h < r_best_h));
    assign w_req_legal = (req_w_in != 8'd0) && (req_w_in <= 8'(FABRIC_W)) &&
                         (req_h_in != 5'd0) && (req_h_in <= 5'd16);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= 4'd0;
            r_w          <= 8'd0;
            r_h          <= 5'd0;
            r_legal      <= 1'b0;
            r_best_found <= 1'b0;
            r_best_id    <= 4'd0;
            r_best_h     <= 5'd0;
            r_best_occ   <= 8'd0;
            r_res_valid  <= 1'b0;
            r_strip_id   <= 4'd0;
            r_occ_w      <= 8'd0;
            r_strike     <= 1'b0;
            for (int k = 1; k <= NUM_STRIPS; k++) r_occ[k] <= 8'd0;
        end else if (clear_in) begin
            r_state      <= IDLE;
            r_idx        <= 4'd0;
            r_best_found <= 1'b0;
            r_res_valid  <= 1'b0;
            r_strip_id   <= 4'd0;
            r_occ_w      <= 8'd0;
            r_strike     <= 1'b0;
            for (int k = 1; k <= NUM_STRIPS; k++) r_occ[k] <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid_in) begin
                        r_w          <= req_w_in;
                        r_h          <= req_h_in;
                        r_legal      <= w_req_legal;
                        r_best_found <= 1'b0;
                        r_best_id    <= 4'd0;
                        r_best_h     <= 5'd0;
                        r_best_occ   <= 8'd0;
                        r_idx        <= 4'd1;
                        r_state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_better) begin
                        r_best_found <= 1'b1;
                        r_best_id    <= r_idx;
                        r_best_h     <= w_cur_h;
                        r_best_occ   <= w_cur_occ;
                    end
                    if (r_idx == 4'(NUM_STRIPS)) begin
                        r_state <= RESP;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                RESP: begin
                    // First RESP cycle publishes the result and commits the occupancy.
                    if (!r_res_valid) begin
                        r_res_valid <= 1'b1;
                        if (r_best_found) begin
                            r_strip_id <= r_best_id;
                            r_occ_w    <= r_best_occ;
                            r_strike   <= 1'b0;
                            for (int k = 1; k <= NUM_STRIPS; k++) begin
                                if (r_best_id == 4'(k)) r_occ[k] <= r_best_occ + r_w;
                            end
                        end else begin
                            r_strip_id <= 4'd0;
                            r_occ_w    <= 8'd0;
                            r_strike   <= 1'b1;
                        end
                    end else if (res_ready_in) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready_out      = (r_state == IDLE);
    assign res_valid_out      = r_res_valid;
    assign strip_ID_out       = r_strip_id;
    assign occupied_width_out = r_occ_w;
    assign strike_flag_out    = r_strike;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_strip_allocator.sv
// Directed plus randomized bench for strip_allocator against a placement model.
module tb_strip_allocator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear_in;
    logic       req_valid_in;
    logic       req_ready_out;
    logic [7:0] req_w_in;
    logic [4:0] req_h_in;
    logic       res_valid_out;
    logic       res_ready_in;
    logic [3:0] strip_ID_out;
    logic [7:0] occupied_width_out;
    logic       strike_flag_out;
    logic [1:0] o_dbg_state;

    int checks   = 0;
    int failures = 0;

    int heights [1:13] = '{8, 8, 9, 7, 10, 6, 11, 5, 12, 4, 16, 16, 16};
    int occ_m   [1:13];

    strip_allocator dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .clear_in           (clear_in),
        .req_valid_in       (req_valid_in),
        .req_ready_out      (req_ready_out),
        .req_w_in           (req_w_in),
        .req_h_in           (req_h_in),
        .res_valid_out      (res_valid_out),
        .res_ready_in       (res_ready_in),
        .strip_ID_out       (strip_ID_out),
        .occupied_width_out (occupied_width_out),
        .strike_flag_out    (strike_flag_out),
        .o_dbg_state        (o_dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input int obs, input int exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 1; k <= 13; k++) occ_m[k] = 0;
    endtask

    // Shortest strip first; among equal heights, lowest ID first.
    task automatic model_place(input int w, input int h, output int id, output int x);
        id = 0;
        x  = 0;
        if (w < 1 || w > 128 || h < 1 || h > 16) return;
        for (int ht = 1; ht <= 16 && id == 0; ht++) begin
            for (int k = 1; k <= 13 && id == 0; k++) begin
                if (heights[k] == ht && ht >= h && occ_m[k] + w <= 128) begin
                    id = k;
                    x  = occ_m[k];
                end
            end
        end
        if (id != 0) occ_m[id] = occ_m[id] + w;
    endtask

    task automatic do_req(input int w, input int h, input int hold, input string tag);
        int exp_id, exp_x, cyc, stable;
        logic [3:0] id0;
        logic [7:0] x0;
        logic       s0;
        model_place(w, h, exp_id, exp_x);
        check(int'(req_ready_out), 1, {tag, "_ready_in_idle"});
        req_w_in     = 8'(w);
        req_h_in     = 5'(h);
        req_valid_in = 1'b1;
        tick();
        req_valid_in = 1'b0;
        cyc = 0;
        while (!res_valid_out && cyc < 40) begin
            tick();
            cyc++;
        end
        check(cyc, 14, {tag, "_latency"});
        check(int'(strip_ID_out), exp_id, {tag, "_strip_id"});
        check(int'(occupied_width_out), exp_x, {tag, "_x"});
        check(int'(strike_flag_out), (exp_id == 0) ? 1 : 0, {tag, "_strike"});
        id0 = strip_ID_out;
        x0  = occupied_width_out;
        s0  = strike_flag_out;
        stable = 1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!res_valid_out || req_ready_out || strip_ID_out !== id0 ||
                occupied_width_out !== x0 || strike_flag_out !== s0) stable = 0;
        end
        if (hold > 0) check(stable, 1, {tag, "_held_stable"});
        res_ready_in = 1'b1;
        tick();
        res_ready_in = 1'b0;
        check(int'(res_valid_out), 0, {tag, "_valid_dropped"});
        check(int'(req_ready_out), 1, {tag, "_ready_back"});
    endtask

    task automatic check_reset_outputs(input string tag);
        check(int'(req_ready_out), 1, {tag, "_ready"});
        check(int'(res_valid_out), 0, {tag, "_valid"});
        check(int'(strip_ID_out), 0, {tag, "_strip_id"});
        check(int'(occupied_width_out), 0, {tag, "_x"});
        check(int'(strike_flag_out), 0, {tag, "_strike"});
    endtask

    initial begin
        int seen;
        rst_n        = 1'b0;
        clear_in     = 1'b0;
        req_valid_in = 1'b0;
        req_w_in     = 8'd0;
        req_h_in     = 5'd0;
        res_ready_in = 1'b0;
        model_clear();
        #22;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Best-fit sequence on the two height-8 strips, including exact fill.
        do_req(100, 8, 0, "r100x8");
        do_req(40, 8, 0, "r40x8");
        do_req(28, 8, 0, "r28x8");
        do_req(1, 8, 0, "r1x8");

        for (int i = 0; i < 4; i++) do_req(128, 16, 0, $sformatf("full16_%0d", i));

        do_req(0, 4, 0, "ill_w0");
        do_req(129, 4, 0, "ill_w129");
        do_req(10, 0, 0, "ill_h0");
        do_req(10, 17, 0, "ill_h17");
        do_req(10, 4, 0, "r10x4");

        do_req(5, 3, 20, "backpressure");

        // Clear sampled at the sixth scan edge discards the request.
        req_w_in     = 8'd20;
        req_h_in     = 5'd4;
        req_valid_in = 1'b1;
        tick();
        req_valid_in = 1'b0;
        repeat (5) tick();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        model_clear();
        check(int'(req_ready_out), 1, "clear_idle");
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid_out) seen = 1;
            tick();
        end
        check(seen, 0, "clear_no_result");
        do_req(28, 5, 0, "after_clear_28x5");
        do_req(128, 16, 0, "after_clear_128x16");

        // Reset asserted while a result is being held.
        req_w_in     = 8'd7;
        req_h_in     = 5'd9;
        req_valid_in = 1'b1;
        tick();
        req_valid_in = 1'b0;
        seen = 0;
        while (!res_valid_out && seen < 40) begin
            tick();
            seen++;
        end
        check(int'(res_valid_out), 1, "pre_reset_valid");
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_resp_reset");
        #2;
        rst_n = 1'b1;
        model_clear();
        tick();

        // Randomized traffic with occasional clears between requests.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                clear_in = 1'b1;
                tick();
                clear_in = 1'b0;
                model_clear();
            end
            do_req(int'($urandom_range(0, 130)), int'($urandom_range(0, 17)),
                   int'($urandom_range(0, 3)), $sformatf("rand_%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
